// File: rtl/fwd_clk_enable_ctrl_if.sv
// rtl/fwd_clk_enable_ctrl_if.sv - control/status bundle for the clock-forwarding enable controller
interface fwd_clk_enable_ctrl_if #(
   parameter int CNT_W = 8
);
   logic             locked_async;
   logic             enable_req;
   logic             cnt_clr;
   logic             fwd_ce;
   logic             fwd_ready;
   logic [2:0]       state_o;
   logic [CNT_W-1:0] lock_loss_cnt;

   // driver side: MMCM flag and software controls in, status out
   modport master (
      output locked_async, enable_req, cnt_clr,
      input  fwd_ce, fwd_ready, state_o, lock_loss_cnt
   );

   // controller side
   modport slave (
      input  locked_async, enable_req, cnt_clr,
      output fwd_ce, fwd_ready, state_o, lock_loss_cnt
   );
endinterface

// File: rtl/fwd_clk_enable_ctrl.sv
// rtl/fwd_clk_enable_ctrl.sv - qualifies MMCM lock before enabling the forwarded-clock ODDR CE
module fwd_clk_enable_ctrl #(
   parameter int SYNC_STAGES    = 2,
   parameter int SETTLE_CYCLES  = 1024,
   parameter int HOLDOFF_CYCLES = 64,
   parameter int CNT_W          = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   fwd_clk_enable_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      OFF       = 3'd0,
      WAIT_LOCK = 3'd1,
      SETTLE    = 3'd2,
      RUN       = 3'd3,
      HOLDOFF   = 3'd4
   } state_t;

   // a 1-cycle window still needs a 1-bit counter
   localparam int SET_W  = (SETTLE_CYCLES  > 1) ? $clog2(SETTLE_CYCLES)  : 1;
   localparam int HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
   localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLDOFF_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   state_t                 state_q, state_d;
   logic [SET_W-1:0]       settle_cnt_q, settle_cnt_d;
   logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
   logic [CNT_W-1:0]       loss_cnt_q, loss_cnt_d;
   logic                   fwd_ce_q, fwd_ce_d;
   logic                   lk;
   logic                   loss_evt;

   assign lk = sync_q[SYNC_STAGES-1];

   // shift the raw locked flag through the synchroniser chain
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], bus.locked_async};
   end

   // next state, window counters and lock-loss event
   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      loss_evt     = 1'b0;
      case (state_q)
         OFF: begin
            if (bus.enable_req) state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (!bus.enable_req) state_d = OFF;
            else if (lk)         state_d = SETTLE;
         end
         SETTLE: begin
            if (!bus.enable_req)             state_d = OFF;
            else if (!lk)                    state_d = WAIT_LOCK;
            else if (settle_cnt_q == SETTLE_LAST) state_d = RUN;
            else                             settle_cnt_d = settle_cnt_q + 1'b1;
         end
         RUN: begin
            // lock loss wins over a simultaneous software disable so it is always counted
            if (!lk) begin
               state_d  = HOLDOFF;
               loss_evt = 1'b1;
            end else if (!bus.enable_req) begin
               state_d = OFF;
            end
         end
         HOLDOFF: begin
            // runs to completion regardless of lk so a flapping lock cannot shorten it
            if (hold_cnt_q == HOLD_LAST) state_d = bus.enable_req ? WAIT_LOCK : OFF;
            else                         hold_cnt_d = hold_cnt_q + 1'b1;
         end
         default: state_d = OFF;
      endcase
      if (state_d != state_q) begin
         settle_cnt_d = '0;
         hold_cnt_d   = '0;
      end
   end

   // saturating lock-loss counter with clear taking priority, and CE decode of next state
   always_comb begin
      loss_cnt_d = loss_cnt_q;
      if (loss_evt && (loss_cnt_q != CNT_MAX)) loss_cnt_d = loss_cnt_q + CNT_W'(1);
      if (bus.cnt_clr) loss_cnt_d = '0;
      fwd_ce_d = (state_d == RUN);
   end

   // synchroniser flops
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= '0;
      else      sync_q <= sync_d;
   end

   // FSM and registered outputs; CE tracks RUN with no extra stage
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= OFF;
         settle_cnt_q <= '0;
         hold_cnt_q   <= '0;
         loss_cnt_q   <= '0;
         fwd_ce_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         settle_cnt_q <= settle_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         loss_cnt_q   <= loss_cnt_d;
         fwd_ce_q     <= fwd_ce_d;
      end
   end

   assign bus.fwd_ce        = fwd_ce_q;
   assign bus.fwd_ready     = fwd_ce_q;
   assign bus.state_o       = state_q;
   assign bus.lock_loss_cnt = loss_cnt_q;

endmodule
